// File: rtl/csr_file.sv
// CSR file: privilege, exception, interrupt and timer control registers.
// Combinational read port, single write port, exception/ertn commit from WB.
module csr_file (
  input  logic        clk,
  input  logic        reset,
  input  logic [79:0] csr_ctrl,
  output logic [31:0] csr_rvalue,
  input  logic        wb_ex,
  input  logic [31:0] wb_pc,
  input  logic [5:0]  wb_ecode,
  input  logic [8:0]  wb_esubcode,
  input  logic        ertn_flush,
  input  logic [7:0]  hw_int,
  output logic [31:0] ex_entry,
  output logic [31:0] era_pc,
  output logic        has_int
);

  localparam logic [13:0] A_CRMD   = 14'h00;
  localparam logic [13:0] A_PRMD   = 14'h01;
  localparam logic [13:0] A_ECFG   = 14'h04;
  localparam logic [13:0] A_ESTAT  = 14'h05;
  localparam logic [13:0] A_ERA    = 14'h06;
  localparam logic [13:0] A_EENTRY = 14'h0C;
  localparam logic [13:0] A_SAVE0  = 14'h30;
  localparam logic [13:0] A_SAVE1  = 14'h31;
  localparam logic [13:0] A_SAVE2  = 14'h32;
  localparam logic [13:0] A_SAVE3  = 14'h33;
  localparam logic [13:0] A_TID    = 14'h40;
  localparam logic [13:0] A_TCFG   = 14'h41;
  localparam logic [13:0] A_TVAL   = 14'h42;
  localparam logic [13:0] A_TICLR  = 14'h44;

  // Software-writable bits of each register.
  localparam logic [31:0] M_CRMD   = 32'h0000_000F;
  localparam logic [31:0] M_PRMD   = 32'h0000_0007;
  localparam logic [31:0] M_ECFG   = 32'h0000_1BFF;
  localparam logic [31:0] M_ESTAT  = 32'h7FFF_0003;
  localparam logic [31:0] M_EENTRY = 32'hFFFF_FFC0;
  localparam logic [31:0] M_ALL    = 32'hFFFF_FFFF;

  typedef enum logic {
    T_IDLE,
    T_RUN
  } tstate_e;

  logic [13:0] csr_num;
  logic        csr_we;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wdata;
  logic        unused_re;

  assign {csr_num, csr_we, csr_wmask, csr_wdata, unused_re} = csr_ctrl;

  logic [31:0] crmd_q, crmd_d;
  logic [31:0] prmd_q, prmd_d;
  logic [31:0] ecfg_q, ecfg_d;
  logic [31:0] estat_q, estat_d;
  logic [31:0] era_q, era_d;
  logic [31:0] eentry_q, eentry_d;
  logic [31:0] save_q [4];
  logic [31:0] save_d [4];
  logic [31:0] tid_q, tid_d;
  logic [31:0] tcfg_q, tcfg_d;
  logic [31:0] tval_q, tval_d;
  tstate_e     state_q, state_d;

  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] m,
    input logic [31:0] d
  );
    return (old & ~m) | (d & m);
  endfunction

  logic sw_we;
  logic wr_crmd, wr_prmd, wr_ecfg, wr_estat;
  logic wr_era, wr_eentry, wr_tid, wr_tcfg, wr_ticlr;
  logic ticlr_clr, expire;
  logic [31:0] tcfg_new;

  assign sw_we     = csr_we & ~wb_ex;
  assign wr_crmd   = sw_we && (csr_num == A_CRMD);
  assign wr_prmd   = sw_we && (csr_num == A_PRMD);
  assign wr_ecfg   = sw_we && (csr_num == A_ECFG);
  assign wr_estat  = sw_we && (csr_num == A_ESTAT);
  assign wr_era    = sw_we && (csr_num == A_ERA);
  assign wr_eentry = sw_we && (csr_num == A_EENTRY);
  assign wr_tid    = sw_we && (csr_num == A_TID);
  assign wr_tcfg   = sw_we && (csr_num == A_TCFG);
  assign wr_ticlr  = sw_we && (csr_num == A_TICLR);
  assign ticlr_clr = wr_ticlr & csr_wmask[0] & csr_wdata[0];
  assign expire    = (state_q == T_RUN) && (tval_q == 32'd0);
  assign tcfg_new  = merge(tcfg_q, csr_wmask & M_ALL, csr_wdata);

  // Privilege / exception registers: wb_ex > ertn > software write.
  always_comb begin
    crmd_d   = crmd_q;
    prmd_d   = prmd_q;
    ecfg_d   = ecfg_q;
    era_d    = era_q;
    eentry_d = eentry_q;
    tid_d    = tid_q;
    for (int i = 0; i < 4; i++) begin
      save_d[i] = save_q[i];
      if (sw_we && (csr_num == A_SAVE0 + 14'(i)))
        save_d[i] = merge(save_q[i], csr_wmask, csr_wdata);
    end
    if (wr_crmd)   crmd_d   = merge(crmd_q, csr_wmask & M_CRMD, csr_wdata);
    if (wr_prmd)   prmd_d   = merge(prmd_q, csr_wmask & M_PRMD, csr_wdata);
    if (wr_ecfg)   ecfg_d   = merge(ecfg_q, csr_wmask & M_ECFG, csr_wdata);
    if (wr_era)    era_d    = merge(era_q, csr_wmask, csr_wdata);
    if (wr_eentry) eentry_d = merge(eentry_q, csr_wmask & M_EENTRY, csr_wdata);
    if (wr_tid)    tid_d    = merge(tid_q, csr_wmask, csr_wdata);
    if (ertn_flush && !wb_ex)
      crmd_d[2:0] = prmd_q[2:0];
    if (wb_ex) begin
      prmd_d[2:0] = crmd_q[2:0];
      crmd_d[2:0] = 3'b000;
      era_d       = wb_pc;
    end
  end

  // ESTAT: sampled hw lines, timer flag, exception cause.
  always_comb begin
    estat_d = estat_q;
    if (wr_estat) estat_d = merge(estat_q, csr_wmask & M_ESTAT, csr_wdata);
    estat_d[9:2] = hw_int;
    estat_d[10]  = 1'b0;
    estat_d[12]  = 1'b0;
    if (ticlr_clr) estat_d[11] = 1'b0;
    if (expire)    estat_d[11] = 1'b1;
    if (wb_ex) begin
      estat_d[21:16] = wb_ecode;
      estat_d[30:22] = wb_esubcode;
    end
  end

  // Timer: countdown in RUN, reload or stop at zero, TCFG writes restart.
  always_comb begin
    tcfg_d  = tcfg_q;
    tval_d  = tval_q;
    state_d = state_q;
    if (state_q == T_RUN) begin
      if (tval_q != 32'd0) begin
        tval_d = tval_q - 32'd1;
      end else if (tcfg_q[1]) begin
        tval_d = {tcfg_q[31:2], 2'b00};
      end else begin
        tval_d  = 32'hFFFF_FFFF;
        state_d = T_IDLE;
      end
    end
    if (wr_tcfg) begin
      tcfg_d = tcfg_new;
      if (tcfg_new[0]) begin
        state_d = T_RUN;
        tval_d  = {tcfg_new[31:2], 2'b00};
      end else begin
        state_d = T_IDLE;
        tval_d  = tval_q;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      crmd_q   <= 32'h0000_0008;
      prmd_q   <= '0;
      ecfg_q   <= '0;
      estat_q  <= '0;
      era_q    <= '0;
      eentry_q <= '0;
      tid_q    <= '0;
      tcfg_q   <= '0;
      tval_q   <= 32'hFFFF_FFFF;
      state_q  <= T_IDLE;
      for (int i = 0; i < 4; i++) save_q[i] <= '0;
    end else begin
      crmd_q   <= crmd_d;
      prmd_q   <= prmd_d;
      ecfg_q   <= ecfg_d;
      estat_q  <= estat_d;
      era_q    <= era_d;
      eentry_q <= eentry_d;
      tid_q    <= tid_d;
      tcfg_q   <= tcfg_d;
      tval_q   <= tval_d;
      state_q  <= state_d;
      for (int i = 0; i < 4; i++) save_q[i] <= save_d[i];
    end
  end

  // Read mux: current register contents, no write forwarding.
  always_comb begin
    csr_rvalue = '0;
    case (csr_num)
      A_CRMD:   csr_rvalue = crmd_q;
      A_PRMD:   csr_rvalue = prmd_q;
      A_ECFG:   csr_rvalue = ecfg_q;
      A_ESTAT:  csr_rvalue = estat_q;
      A_ERA:    csr_rvalue = era_q;
      A_EENTRY: csr_rvalue = eentry_q;
      A_SAVE0:  csr_rvalue = save_q[0];
      A_SAVE1:  csr_rvalue = save_q[1];
      A_SAVE2:  csr_rvalue = save_q[2];
      A_SAVE3:  csr_rvalue = save_q[3];
      A_TID:    csr_rvalue = tid_q;
      A_TCFG:   csr_rvalue = tcfg_q;
      A_TVAL:   csr_rvalue = tval_q;
      default:  csr_rvalue = '0;
    endcase
  end

  assign ex_entry = eentry_q;
  assign era_pc   = era_q;
  assign has_int  = crmd_q[2] & |(estat_q[12:0] & ecfg_q[12:0]);

endmodule

// File: tb/tb_csr_file.sv
// Directed-vector bench for csr_file.
// Stimulus queues expected results; a negedge monitor pops and compares.
module tb_csr_file;

  logic        clk;
  logic        reset;
  logic [79:0] csr_ctrl;
  logic [31:0] csr_rvalue;
  logic        wb_ex;
  logic [31:0] wb_pc;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic        ertn_flush;
  logic [7:0]  hw_int;
  logic [31:0] ex_entry;
  logic [31:0] era_pc;
  logic        has_int;

  logic [13:0] c_num;
  logic        c_we;
  logic [31:0] c_mask;
  logic [31:0] c_data;

  assign csr_ctrl = {c_num, c_we, c_mask, c_data, 1'b1};

  csr_file dut (
    .clk         (clk),
    .reset       (reset),
    .csr_ctrl    (csr_ctrl),
    .csr_rvalue  (csr_rvalue),
    .wb_ex       (wb_ex),
    .wb_pc       (wb_pc),
    .wb_ecode    (wb_ecode),
    .wb_esubcode (wb_esubcode),
    .ertn_flush  (ertn_flush),
    .hw_int      (hw_int),
    .ex_entry    (ex_entry),
    .era_pc      (era_pc),
    .has_int     (has_int)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [31:0] act;
  logic        chk_v;
  int          n_tests;
  int          n_fail;

  localparam int S_RD  = 0;
  localparam int S_INT = 1;
  localparam int S_ERA = 2;
  localparam int S_ENT = 3;

  // Monitor: DUT output is presented whenever chk_v is high.
  always @(negedge clk) begin
    if (chk_v) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_empty: got output with no expected entry");
      end else begin
        e = sb.pop_front();
        case (e.sel)
          S_INT:   act = {31'b0, has_int};
          S_ERA:   act = era_pc;
          S_ENT:   act = ex_entry;
          default: act = csr_rvalue;
        endcase
        if (act !== e.exp) begin
          n_fail++;
          $display("FAIL %s: got %h, want %h", e.name, act, e.exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int sel,
                     input logic [13:0] num, input logic [31:0] exp);
    exp_t x;
    x.name = name;
    x.sel  = sel;
    x.exp  = exp;
    c_num  = num;
    chk_v  = 1'b1;
    sb.push_back(x);
    tick();
    chk_v  = 1'b0;
  endtask

  task automatic wr(input logic [13:0] num, input logic [31:0] mask,
                    input logic [31:0] data);
    c_num  = num;
    c_we   = 1'b1;
    c_mask = mask;
    c_data = data;
    tick();
    c_we   = 1'b0;
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    chk_v       = 1'b0;
    reset       = 1'b1;
    c_num       = '0;
    c_we        = 1'b0;
    c_mask      = '0;
    c_data      = '0;
    wb_ex       = 1'b0;
    wb_pc       = '0;
    wb_ecode    = '0;
    wb_esubcode = '0;
    ertn_flush  = 1'b0;
    hw_int      = '0;
    tick();
    tick();
    reset = 1'b0;

    chk("rst_crmd", S_RD, 14'h00, 32'h0000_0008);
    chk("rst_prmd", S_RD, 14'h01, 32'h0);
    chk("rst_estat", S_RD, 14'h05, 32'h0);
    chk("rst_tval", S_RD, 14'h42, 32'hFFFF_FFFF);
    chk("rst_save1", S_RD, 14'h31, 32'h0);
    chk("rst_has_int", S_INT, 14'h00, 32'h0);
    chk("rst_era_pc", S_ERA, 14'h00, 32'h0);
    chk("rst_ex_entry", S_ENT, 14'h00, 32'h0);
    chk("unmapped", S_RD, 14'h07, 32'h0);

    wr(14'h31, 32'hFFFF_0000, 32'hDEAD_BEEF);
    chk("save1_hi", S_RD, 14'h31, 32'hDEAD_0000);
    wr(14'h31, 32'h0000_FFFF, 32'h1234_5678);
    chk("save1_lo", S_RD, 14'h31, 32'hDEAD_5678);

    wr(14'h04, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("ecfg_rsvd", S_RD, 14'h04, 32'h0000_1BFF);
    wr(14'h04, 32'hFFFF_FFFF, 32'h0);
    wr(14'h0C, 32'hFFFF_FFFF, 32'h1C00_8ABC);
    chk("eentry", S_RD, 14'h0C, 32'h1C00_8A80);
    chk("ex_entry", S_ENT, 14'h0C, 32'h1C00_8A80);
    wr(14'h42, 32'hFFFF_FFFF, 32'h0);
    chk("tval_ro", S_RD, 14'h42, 32'hFFFF_FFFF);
    wr(14'h05, 32'hFFFF_FFFF, 32'h0000_1FFF);
    chk("estat_is_ro", S_RD, 14'h05, 32'h0000_0003);
    wr(14'h05, 32'hFFFF_FFFF, 32'h0);
    chk("ticlr_rd0", S_RD, 14'h44, 32'h0);

    wr(14'h00, 32'hFFFF_FFFF, 32'h0000_0007);
    chk("crmd_set", S_RD, 14'h00, 32'h0000_0007);
    wb_ex       = 1'b1;
    wb_pc       = 32'h1C00_0100;
    wb_ecode    = 6'h0B;
    wb_esubcode = 9'h001;
    tick();
    wb_ex = 1'b0;
    chk("ex_prmd", S_RD, 14'h01, 32'h0000_0007);
    chk("ex_crmd", S_RD, 14'h00, 32'h0);
    chk("ex_era", S_RD, 14'h06, 32'h1C00_0100);
    chk("ex_era_pc", S_ERA, 14'h06, 32'h1C00_0100);
    chk("ex_estat", S_RD, 14'h05, 32'h004B_0000);
    ertn_flush = 1'b1;
    tick();
    ertn_flush = 1'b0;
    chk("ertn_crmd", S_RD, 14'h00, 32'h0000_0007);

    c_num       = 14'h06;
    c_we        = 1'b1;
    c_mask      = 32'hFFFF_FFFF;
    c_data      = 32'h1234_5678;
    wb_ex       = 1'b1;
    wb_pc       = 32'h1C00_0200;
    wb_ecode    = 6'h02;
    wb_esubcode = 9'h000;
    tick();
    c_we  = 1'b0;
    wb_ex = 1'b0;
    chk("ex_blocks_wr", S_RD, 14'h06, 32'h1C00_0200);
    chk("ex2_crmd", S_RD, 14'h00, 32'h0);

    c_num      = 14'h00;
    c_we       = 1'b1;
    c_mask     = 32'hFFFF_FFFF;
    c_data     = 32'h0000_0009;
    ertn_flush = 1'b1;
    tick();
    c_we       = 1'b0;
    ertn_flush = 1'b0;
    chk("ertn_vs_wr", S_RD, 14'h00, 32'h0000_000F);

    wr(14'h04, 32'hFFFF_FFFF, 32'h0000_0004);
    hw_int = 8'h01;
    chk("int_lag", S_INT, 14'h05, 32'h0);
    chk("int_on", S_INT, 14'h05, 32'h1);
    chk("int_estat", S_RD, 14'h05, 32'h0002_0004);
    hw_int = 8'h00;
    tick();
    chk("int_off", S_INT, 14'h05, 32'h0);

    wr(14'h41, 32'hFFFF_FFFF, 32'h0000_000F);
    for (int v = 12; v >= 0; v--)
      chk($sformatf("tval_%0d", v), S_RD, 14'h42, 32'(v));
    chk("tim_set", S_RD, 14'h05, 32'h0002_0800);
    chk("tim_reload", S_RD, 14'h42, 32'd11);
    wr(14'h44, 32'h0000_0001, 32'h0000_0001);
    chk("ticlr", S_RD, 14'h05, 32'h0002_0000);
    chk("tval_8", S_RD, 14'h42, 32'd8);
    repeat (6) tick();
    chk("tval_1", S_RD, 14'h42, 32'd1);
    wr(14'h44, 32'h0000_0001, 32'h0000_0001);
    chk("set_wins", S_RD, 14'h05, 32'h0002_0800);

    wr(14'h44, 32'h0000_0001, 32'h0000_0001);
    wr(14'h41, 32'hFFFF_FFFF, 32'h0000_0009);
    chk("os_tval_8", S_RD, 14'h42, 32'd8);
    repeat (7) tick();
    chk("os_tval_0", S_RD, 14'h42, 32'd0);
    chk("os_stop", S_RD, 14'h42, 32'hFFFF_FFFF);
    chk("os_idle", S_RD, 14'h42, 32'hFFFF_FFFF);
    chk("os_set", S_RD, 14'h05, 32'h0002_0800);

    wr(14'h41, 32'hFFFF_FFFF, 32'h0000_000F);
    chk("re_tval_12", S_RD, 14'h42, 32'd12);
    wr(14'h41, 32'hFFFF_FFFF, 32'h0000_000E);
    chk("dis_hold", S_RD, 14'h42, 32'd11);
    chk("dis_hold2", S_RD, 14'h42, 32'd11);

    wr(14'h41, 32'hFFFF_FFFF, 32'h0000_000F);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_tval", S_RD, 14'h42, 32'hFFFF_FFFF);
    chk("mid_rst_tcfg", S_RD, 14'h41, 32'h0);
    chk("mid_rst_estat", S_RD, 14'h05, 32'h0);
    chk("mid_rst_hold", S_RD, 14'h42, 32'hFFFF_FFFF);
    chk("mid_rst_crmd", S_RD, 14'h00, 32'h0000_0008);

    tick();
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL sb_drain: got %0d left, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/csr_file.md
CSR_FILE -- requirements
Module: csr_file

Interface
REQ-001 SHALL have these ports (name  direction  width  meaning):
- clk  in  1  single clock; all state on rising edge
- reset  in  1  synchronous, active-high reset
- csr_ctrl  in  80  {csr_num[13:0], csr_we, csr_wmask[31:0], csr_wdata[31:0], csr_re}, MSB first
- csr_rvalue  out  32  combinational read data for csr_num
- wb_ex  in  1  exception commit from WB
- wb_pc  in  32  PC of the excepting instruction
- wb_ecode  in  6  exception code
- wb_esubcode  in  9  exception subcode
- ertn_flush  in  1  ertn commit from WB
- hw_int  in  8  hardware interrupt lines, level-sensitive
- ex_entry  out  32  current EENTRY value
- era_pc  out  32  current ERA value
- has_int  out  1  interrupt pending and enabled

REQ-002 SHALL implement these CSRs (address: fields):
- CRMD 0x00: PLV[1:0], IE[2], DA[3]
- PRMD 0x01: PPLV[1:0], PIE[2]
- ECFG 0x04: LIE[12:0], with bit 10 reserved as 0
- ESTAT 0x05: IS[12:0], Ecode[21:16], EsubCode[30:22]
- ERA 0x06: [31:0]
- EENTRY 0x0C: VA[31:6]
- SAVE0..3 0x30..0x33: [31:0]
- TID 0x40: [31:0]
- TCFG 0x41: En[0], Periodic[1], InitVal[31:2]
- TVAL 0x42: read-only
- TICLR 0x44: CLR[0], write-only, reads 0
- All unlisted bits and unlisted addresses SHALL read 0.

Function
REQ-003 SHALL make csr_rvalue combinational from csr_num, with zero added latency. Same-cycle writes SHALL NOT be forwarded.
REQ-004 SHALL apply a CSR write when csr_we=1 and wb_ex=0, at the next edge: new = (old & ~csr_wmask) | (csr_wdata & csr_wmask), restricted to software-writable fields.
REQ-005 SHALL treat these fields as read-only to software: ESTAT.IS[12:2], and all of TVAL. ESTAT.IS[1:0] SHALL be software-writable.
REQ-006 SHALL sample hw_int into ESTAT.IS[9:2] every cycle. ESTAT.IS[10] SHALL be 0.
REQ-007 SHALL apply these updates at the edge where wb_ex=1:
- PRMD.PPLV<=CRMD.PLV and PRMD.PIE<=CRMD.IE
- CRMD.PLV<=0 and CRMD.IE<=0
- ERA<=wb_pc
- ESTAT.Ecode<=wb_ecode and ESTAT.EsubCode<=wb_esubcode
REQ-008 SHALL, when ertn_flush=1 and wb_ex=0, load CRMD.PLV<=PRMD.PPLV and CRMD.IE<=PRMD.PIE.
REQ-009 SHALL apply priority per cycle: wb_ex > ertn_flush > software write. Fields untouched by the winning event SHALL still take the software write, except when wb_ex=1, which blocks all software writes.
REQ-010 SHALL drive ex_entry = {EENTRY.VA, 6'b0} and era_pc = ERA, combinationally.
REQ-011 SHALL drive has_int = CRMD.IE & |(ESTAT.IS[12:0] & ECFG.LIE[12:0]).
REQ-012 SHALL implement timer state as a 2-state FSM:
- IDLE->RUN on a TCFG write with En=1; TVAL<={InitVal,2'b00} at the same edge.
- RUN->IDLE on a TCFG write with En=0; TVAL holds its value.
REQ-013 SHALL behave in RUN as follows:
- TVAL!=0: TVAL decrements by 1 per cycle.
- TVAL==0: set ESTAT.IS[11]. If Periodic=1, TVAL<={InitVal,2'b00} and stay in RUN. If Periodic=0, TVAL<=32'hFFFFFFFF and go to IDLE.
REQ-014 SHALL clear ESTAT.IS[11] on a TICLR write with CLR=1 and csr_wmask[0]=1. If that clear coincides with a timer expiry, the set SHALL win.
REQ-015 SHALL make TVAL wrap only by reload. Counting SHALL NOT pass below 0.
REQ-016 SHALL use a TCFG write in RUN to reload TVAL from the new InitVal, restarting the count.

Reset
REQ-017 SHALL, while reset=1 at an edge, set:
- CRMD = 0x00000008 (PLV=0, IE=0, DA=1)
- PRMD, ECFG, ESTAT, TCFG = 0
- timer FSM = IDLE
- TVAL = 32'hFFFFFFFF
REQ-018 SHALL leave ERA, EENTRY, SAVE0..3 and TID at 0 after reset. Reset SHALL override every concurrent event, including one mid-count.
REQ-019 SHALL hold outputs after reset at: has_int=0, ex_entry=0, era_pc=0.

Verification
REQ-020 Write SAVE1 with wdata=0xDEADBEEF, mask=0xFFFF0000 -> next cycle, reading 0x31 gives 0xDEAD0000.
REQ-021 Set CRMD.PLV=3, IE=1; pulse wb_ex with pc=0x1C000100, ecode=0x0B -> PRMD=0x7, CRMD.PLV=0/IE=0, ERA=0x1C000100, ESTAT[21:16]=0x0B. Then ertn_flush -> CRMD.PLV=3, IE=1.
REQ-022 Write TCFG=0x0000000F (InitVal=3, periodic, En) -> TVAL reads 12,11,...,0, then IS[11]=1 and reload to 12. Write TICLR=1 -> IS[11]=0.
REQ-023 Pulse wb_ex with csr_we=1 to ERA, wdata=0x12345678, in the same cycle -> ERA=wb_pc and the write is dropped.
REQ-024 Set ECFG.LIE[2]=1, CRMD.IE=1, hw_int=0x01 -> has_int=1 one cycle later. Drop hw_int to 0 -> has_int=0.
REQ-025 Assert reset while the timer is mid-count -> TVAL=0xFFFFFFFF, TCFG=0, IS=0, and no further decrement.
